rpn_controller: RTL
===================

// Module: rpn_controller
// PURPOSE
//  Next-generation calculator controller: RPN entry with a parametrised operand stack.
//  Sits between the keypad decoder and the display register and ALU, like controller.
//  X lives in the external display register; Y..T live in an internal LIFO.
//  Talks to the ALU through a start/done handshake, with a timeout.
// PARAMETERS
//  STACK_DEPTH     4   total levels incl. X; internal LIFO holds STACK_DEPTH-1 (>=2)
//  TIMEOUT_CYCLES  64  max cycles from alu_start_o to alu_done_i before error
// PORTS
//  clk_i            in   1      clock
//  rst_i            in   1      synchronous, active-high reset
//  active_button_i  in   active_button_t  decoded button
//  new_input_i      in   1      button valid this cycle
//  display_we_o     out  1      display register write enable
//  display_wdata_o  out  num_t  display write data
//  display_rdata_i  in   num_t  display (X) contents
//  alu_left_o       out  num_t  Y operand
//  alu_right_o      out  num_t  X operand
//  alu_op_o         out  op_t   operation
//  alu_start_o      out  1      one-cycle start pulse
//  alu_done_i       in   1      result valid pulse
//  alu_result_i     in   num_t  ALU result
//  busy_o           out  1      ALU op in flight; buttons ignored
//  error_o          out  1      sticky error until B_CLEAR or reset
//  stack_count_o    out  $clog2(STACK_DEPTH)  internal LIFO occupancy
// BEHAVIOUR
//  Reset: state IDLE, LIFO empty, count 0, lift_en=0, entry_active=0, all outputs 0.
//  Button accepted on a clock edge with new_input_i=1 in IDLE. Ignored in BUSY (no queue).
//  Writes are combinational in the accept cycle and land at that edge. Result is visible next cycle.
//  Digit, entry_active=1: display <= append_digit(X,d). 1 cycle.
//  Digit, entry_active=0: if lift_en, push X, then display <= d.
//   Push and display write happen at the same edge. Sets entry_active=1, lift_en=0.
//  ENTER (B_OP_EQ): push X, X unchanged, lift_en=0, entry_active=0.
//  Operator with count==0: state ERROR, no ALU start, display unchanged.
//  Operator with count>0: alu_left_o=Y, alu_right_o=X, alu_start_o=1 for 1 cycle.
//   Then state BUSY, with busy_o=1 from the cycle after accept until done.
//   Operands and op are held stable while BUSY.
//   On alu_done_i: display <= alu_result_i, pop Y, lift_en=1, entry_active=0, state IDLE.
//   Timeout counter reaches TIMEOUT_CYCLES with no done: state ERROR, stack and X unchanged.
//  Push with LIFO full: see CONFIGURATION.
//  ERROR: error_o=1, busy_o=0. Only B_CLEAR is accepted.
//   B_CLEAR empties the LIFO, zeroes display, sets state IDLE.
//   B_CLEAR in IDLE does the same.
//  alu_done_i outside BUSY is ignored (covers a late done after reset or timeout).
//  Reset mid-BUSY: full reset. A pending done is then ignored.
// CONFIGURATION
//  CALC_RPN_ROLL_EN defined: push on full LIFO discards the oldest level.
//   Count stays STACK_DEPTH-1 and there is no error.
//  Not defined: push on full LIFO is dropped, state ERROR, error_o=1.
// STRUCTURE
//  calc_pkg adds:
//   rpn_state_t {IDLE, BUSY, ERROR}
//   B_CLEAR in active_button_t
//   functions is_digit(), button_to_op(), append_digit()
//  Sub-module rpn_stack #(DEPTH): LIFO with push/pop/top/count.
//   Its roll-on-full input is driven by the macro.
// TESTING (digit = display significand[7]; ALU latency 1, STACK_DEPTH=4)
//  3,ENTER,4,ADD -> busy_o 1 cycle, display 7, count 0, error 0.
//  ADD from reset -> error_o=1, display 0, no alu_start_o. Then B_CLEAR -> error_o=0.
//  1,ENTER x4 -> count 3 after 3rd ENTER.
//   4th ENTER, no macro: error_o=1. With CALC_RPN_ROLL_EN: count 3, error 0.
//  2,ENTER,3,ADD,4 -> display 4, count 1 (5 lifted). Then ADD -> display 9, count 0.
//  Hold alu_done_i=0 -> error_o at TIMEOUT_CYCLES after start. Stack and X unchanged.
//  Reset during BUSY, then done pulse 2 cycles later -> display 0, count 0, no write.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and helpers for the RPN calculator controller: number format,
// keypad buttons, ALU ops, controller states and digit-entry helpers.
package calc_pkg;

    localparam int NUM_DIGITS = 8;

    // Left-justified BCD significand; exponent counts digits entered after the first.
    typedef struct packed {
        logic [3:0]                  exponent;
        logic [NUM_DIGITS-1:0][3:0]  significand;
    } num_t;

    typedef enum logic [4:0] {
        B_0, B_1, B_2, B_3, B_4, B_5, B_6, B_7, B_8, B_9,
        B_OP_EQ, B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV, B_CLEAR
    } active_button_t;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

    typedef enum logic [1:0] {IDLE, BUSY, ERROR} rpn_state_t;

    function automatic logic is_digit(active_button_t b);
        return b <= B_9;
    endfunction

    function automatic logic is_op(active_button_t b);
        return b inside {B_OP_ADD, B_OP_SUB, B_OP_MUL, B_OP_DIV};
    endfunction

    function automatic op_t button_to_op(active_button_t b);
        case (b)
            B_OP_SUB: return OP_SUB;
            B_OP_MUL: return OP_MUL;
            B_OP_DIV: return OP_DIV;
            default:  return OP_ADD;
        endcase
    endfunction

    function automatic num_t digit_to_num(logic [3:0] d);
        num_t r;
        r = '0;
        r.significand[NUM_DIGITS-1] = d;
        return r;
    endfunction

    // Extra digits beyond the display width are silently dropped.
    function automatic num_t append_digit(num_t x, logic [3:0] d);
        num_t r;
        r = x;
        if (x.exponent < 4'(NUM_DIGITS - 1)) begin
            r.exponent = x.exponent + 4'd1;
            r.significand[3'(NUM_DIGITS - 2 - int'(x.exponent))] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/rpn_stack.sv
// Operand LIFO for the Y..T levels. Index 0 is the top (Y); a push on a full
// stack either rolls the oldest level off or is dropped, selected by roll.
module rpn_stack
    import calc_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic          roll,
    input  num_t          din,
    output num_t          top,
    output logic [CW-1:0] count,
    output logic          full
);

    num_t mem [DEPTH];

    assign top  = mem[0];
    assign full = (count == CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
        end else if (push && (!full || roll)) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
            if (!full) count <= count + CW'(1);
        end else if (pop && count != '0) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/rpn_controller.sv
// RPN calculator controller: X in the external display register, Y..T in rpn_stack,
// ALU via start/done with timeout. Define CALC_RPN_ROLL_EN to roll a full stack on push.
module rpn_controller
    import calc_pkg::*;
#(
    parameter int STACK_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  active_button_t                 active_button_i,
    input  logic                           new_input_i,
    output logic                           display_we_o,
    output num_t                           display_wdata_o,
    input  num_t                           display_rdata_i,
    output num_t                           alu_left_o,
    output num_t                           alu_right_o,
    output op_t                            alu_op_o,
    output logic                           alu_start_o,
    input  logic                           alu_done_i,
    input  num_t                           alu_result_i,
    output logic                           busy_o,
    output logic                           error_o,
    output logic [$clog2(STACK_DEPTH)-1:0] stack_count_o
);

    localparam int CW = $clog2(STACK_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef CALC_RPN_ROLL_EN
    localparam logic ROLL = 1'b1;
`else
    localparam logic ROLL = 1'b0;
`endif

    rpn_state_t    state, state_n;
    logic          lift_en, lift_en_n, entry_active, entry_active_n;
    logic [TW-1:0] timer;
    num_t          left_q, right_q;
    op_t           op_q;
    logic          push, pop, clear, full, start;
    num_t          top;
    logic [CW-1:0] count;
    logic [3:0]    digit;

    assign digit = 4'(active_button_i);

    rpn_stack #(.DEPTH(STACK_DEPTH - 1), .CW(CW)) u_stack (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .roll  (ROLL),
        .din   (display_rdata_i),
        .top   (top),
        .count (count),
        .full  (full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            lift_en      <= 1'b0;
            entry_active <= 1'b0;
            timer        <= '0;
            left_q       <= '0;
            right_q      <= '0;
            op_q         <= OP_ADD;
        end else begin
            state        <= state_n;
            lift_en      <= lift_en_n;
            entry_active <= entry_active_n;
            if (start) begin
                timer   <= TW'(1);
                left_q  <= top;
                right_q <= display_rdata_i;
                op_q    <= button_to_op(active_button_i);
            end else if (state == BUSY) begin
                timer <= timer + TW'(1);
            end
        end
    end

    always_comb begin
        state_n         = state;
        lift_en_n       = lift_en;
        entry_active_n  = entry_active;
        display_we_o    = 1'b0;
        display_wdata_o = '0;
        start           = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        clear           = 1'b0;
        case (state)
            IDLE: if (new_input_i) begin
                if (is_digit(active_button_i)) begin
                    if (entry_active) begin
                        display_we_o    = 1'b1;
                        display_wdata_o = append_digit(display_rdata_i, digit);
                    end else if (lift_en && full && !ROLL) begin
                        state_n = ERROR;
                    end else begin
                        push            = lift_en;
                        display_we_o    = 1'b1;
                        display_wdata_o = digit_to_num(digit);
                        entry_active_n  = 1'b1;
                        lift_en_n       = 1'b0;
                    end
                end else if (active_button_i == B_OP_EQ) begin
                    if (full && !ROLL) begin
                        state_n = ERROR;
                    end else begin
                        push           = 1'b1;
                        lift_en_n      = 1'b0;
                        entry_active_n = 1'b0;
                    end
                end else if (active_button_i == B_CLEAR) begin
                    clear          = 1'b1;
                    display_we_o   = 1'b1;
                    lift_en_n      = 1'b0;
                    entry_active_n = 1'b0;
                end else if (is_op(active_button_i)) begin
                    if (count == '0) begin
                        state_n = ERROR;
                    end else begin
                        start   = 1'b1;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (alu_done_i) begin
                    display_we_o    = 1'b1;
                    display_wdata_o = alu_result_i;
                    pop             = 1'b1;
                    lift_en_n       = 1'b1;
                    entry_active_n  = 1'b0;
                    state_n         = IDLE;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = ERROR;
                end
            end
            ERROR: if (new_input_i && active_button_i == B_CLEAR) begin
                clear          = 1'b1;
                display_we_o   = 1'b1;
                lift_en_n      = 1'b0;
                entry_active_n = 1'b0;
                state_n        = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operands come straight from Y/X in the start cycle, then from the capture regs.
    assign alu_start_o   = start;
    assign alu_left_o    = start ? top : left_q;
    assign alu_right_o   = start ? display_rdata_i : right_q;
    assign alu_op_o      = start ? button_to_op(active_button_i) : op_q;
    assign busy_o        = (state == BUSY);
    assign error_o       = (state == ERROR);
    assign stack_count_o = count;

endmodule
